// File: rtl/hidden_layer.sv
// hidden_layer
// Computes the two-neuron hidden layer for every sample row of X_RAM and
// stores sigmoid(pre-activation) results into hRES_RAM.
//
// Ports
//   clk, resetn            : clock, synchronous active-low reset
//   Start / Done           : run request (level-sampled in IDLE) / one-cycle
//                            completion pulse
//   X_read_*               : feature RAM read port (row-major, r*7+f)
//   whid_read_*            : weight RAM read port (j*8+i, i=0 is bias)
//   sigm_read_*            : sigmoid lookup RAM read port
//   hRES_write_*           : result RAM write port (2r+j)
//
// Handshake: Start is sampled only in IDLE; any level seen there begins a run.
// All RAMs are synchronous-read, so data arrives one cycle after the address.
// All RAM-side outputs are decoded from the current state and counters, so
// they are zero whenever the FSM sits in IDLE (including right after reset).
module hidden_layer #(
  parameter int width           = 8,
  parameter int X_depth_bits    = 9,
  parameter int whid_depth_bits = 4,
  parameter int sigm_depth_bits = 8,
  parameter int hRES_depth_bits = 7,
  parameter int num_rows        = 64,
  parameter int num_features    = 7
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       Start,
  output logic                       Done,
  output logic                       X_read_en,
  output logic [X_depth_bits-1:0]    X_read_address,
  input  logic [width-1:0]           X_read_data_out,
  output logic                       whid_read_en,
  output logic [whid_depth_bits-1:0] whid_read_address,
  input  logic [width-1:0]           whid_read_data_out,
  output logic                       sigm_read_en,
  output logic [sigm_depth_bits-1:0] sigm_read_address,
  input  logic [width-1:0]           sigm_read_data_out,
  output logic                       hRES_write_en,
  output logic [hRES_depth_bits-1:0] hRES_write_address,
  output logic [width-1:0]           hRES_write_data_in
);

  localparam int acc_w   = 2 * width + 3;          // sum of 7 products
  localparam int sum_w   = acc_w - width + 1;      // (acc >> width) + bias
  localparam int row_w   = $clog2(num_rows);
  localparam int cnt_w   = 5;
  localparam int num_w   = 2 ** whid_depth_bits;
  localparam logic [cnt_w-1:0] load_last = cnt_w'(num_w);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_MAC, S_MAC_LAST, S_SIG0, S_SIG1, S_WR1, S_DONE
  } state_t;

  state_t state, state_next;

  logic [cnt_w-1:0]           cnt;
  logic [row_w-1:0]           row;
  logic [width-1:0]           w [num_w];
  logic [acc_w-1:0]           acc0, acc1;
  logic [2*width-1:0]         prod0, prod1;
  logic [sum_w-1:0]           sum0, sum1;
  logic [width-1:0]           pre0, pre1;
  logic [whid_depth_bits-1:0] load_idx;
  logic                       last_row;

  // Weight capture lags the issued address by one cycle; on the final LOAD_W
  // cycle (cnt=16) the low bits wrap to 0 so the index lands on 15.
  assign load_idx = whid_depth_bits'(cnt) - 1'b1;
  assign last_row = (row == row_w'(num_rows - 1));

  // During MAC cycle c (and MAC_LAST with cnt=7) the data bus holds feature
  // c-1, whose weights sit at whid index c (neuron 0) and 8+c (neuron 1).
  assign prod0 = X_read_data_out * w[{1'b0, cnt[2:0]}];
  assign prod1 = X_read_data_out * w[{1'b1, cnt[2:0]}];

  // Truncating shift plus bias, saturated at the top of the sigmoid table.
  assign sum0 = sum_w'(acc0 >> width) + sum_w'(w[0]);
  assign sum1 = sum_w'(acc1 >> width) + sum_w'(w[8]);
  assign pre0 = (sum0 > sum_w'(2 ** width - 1)) ? '1 : sum0[width-1:0];
  assign pre1 = (sum1 > sum_w'(2 ** width - 1)) ? '1 : sum1[width-1:0];

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (Start) state_next = S_LOAD_W;
      S_LOAD_W:   if (cnt == load_last) state_next = S_MAC;
      S_MAC:      if (cnt == cnt_w'(num_features - 1)) state_next = S_MAC_LAST;
      S_MAC_LAST: state_next = S_SIG0;
      S_SIG0:     state_next = S_SIG1;
      S_SIG1:     state_next = S_WR1;
      S_WR1:      state_next = last_row ? S_DONE : S_MAC;
      S_DONE:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_comb begin
    Done               = 1'b0;
    X_read_en          = 1'b0;
    X_read_address     = '0;
    whid_read_en       = 1'b0;
    whid_read_address  = '0;
    sigm_read_en       = 1'b0;
    sigm_read_address  = '0;
    hRES_write_en      = 1'b0;
    hRES_write_address = '0;
    hRES_write_data_in = '0;
    case (state)
      S_LOAD_W: begin
        if (cnt < load_last) begin
          whid_read_en      = 1'b1;
          whid_read_address = whid_depth_bits'(cnt);
        end
      end
      S_MAC: begin
        X_read_en      = 1'b1;
        X_read_address = X_depth_bits'(row) * X_depth_bits'(num_features)
                         + X_depth_bits'(cnt);
      end
      S_SIG0: begin
        sigm_read_en      = 1'b1;
        sigm_read_address = sigm_depth_bits'(pre0);
      end
      S_SIG1: begin
        sigm_read_en       = 1'b1;
        sigm_read_address  = sigm_depth_bits'(pre1);
        hRES_write_en      = 1'b1;
        hRES_write_address = hRES_depth_bits'({row, 1'b0});
        hRES_write_data_in = sigm_read_data_out;
      end
      S_WR1: begin
        hRES_write_en      = 1'b1;
        hRES_write_address = hRES_depth_bits'({row, 1'b1});
        hRES_write_data_in = sigm_read_data_out;
      end
      S_DONE:  Done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt  <= '0;
      row  <= '0;
      acc0 <= '0;
      acc1 <= '0;
      for (int i = 0; i < num_w; i++) w[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (Start) begin
            row  <= '0;
            acc0 <= '0;
            acc1 <= '0;
          end
        end
        S_LOAD_W: begin
          if (cnt != '0) w[load_idx] <= whid_read_data_out;
          cnt <= (cnt == load_last) ? '0 : cnt + 1'b1;
        end
        // cnt runs 0..6 in MAC and reaches 7 in MAC_LAST, which selects the
        // last feature's weights without a separate index.
        S_MAC, S_MAC_LAST: begin
          if (cnt != '0) begin
            acc0 <= acc0 + acc_w'(prod0);
            acc1 <= acc1 + acc_w'(prod1);
          end
          cnt <= (state == S_MAC_LAST) ? '0 : cnt + 1'b1;
        end
        S_WR1: begin
          acc0 <= '0;
          acc1 <= '0;
          if (!last_row) row <= row + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hidden_layer.sv
// tb_hidden_layer
// Drives hidden_layer with behavioural synchronous RAMs, builds expected hRES
// contents from the arithmetic rules (dot product, truncating shift, bias,
// saturation, sigmoid lookup) and compares every write as it happens.
module tb_hidden_layer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       Start = 1'b0;
  logic       Done;
  logic       X_read_en;
  logic [8:0] X_read_address;
  logic [7:0] X_read_data_out = '0;
  logic       whid_read_en;
  logic [3:0] whid_read_address;
  logic [7:0] whid_read_data_out = '0;
  logic       sigm_read_en;
  logic [7:0] sigm_read_address;
  logic [7:0] sigm_read_data_out = '0;
  logic       hRES_write_en;
  logic [6:0] hRES_write_address;
  logic [7:0] hRES_write_data_in;

  logic [7:0] x_mem    [512];
  logic [7:0] whid_mem [16];
  logic [7:0] sigm_mem [256];
  logic [7:0] hres_mem [128];

  logic [7:0] exp_q [$];
  logic [6:0] exp_addr;
  int n_vec = 0;
  int n_err = 0;
  int wr_cnt, done_cnt, bad_bus, unexp;

  hidden_layer dut (
    .clk                (clk),
    .resetn             (resetn),
    .Start              (Start),
    .Done               (Done),
    .X_read_en          (X_read_en),
    .X_read_address     (X_read_address),
    .X_read_data_out    (X_read_data_out),
    .whid_read_en       (whid_read_en),
    .whid_read_address  (whid_read_address),
    .whid_read_data_out (whid_read_data_out),
    .sigm_read_en       (sigm_read_en),
    .sigm_read_address  (sigm_read_address),
    .sigm_read_data_out (sigm_read_data_out),
    .hRES_write_en      (hRES_write_en),
    .hRES_write_address (hRES_write_address),
    .hRES_write_data_in (hRES_write_data_in)
  );

  // clock / reset
  always #5 clk = ~clk;

  // synchronous-read RAM models
  always @(posedge clk) begin
    if (X_read_en)     X_read_data_out    <= x_mem[X_read_address];
    if (whid_read_en)  whid_read_data_out <= whid_mem[whid_read_address];
    if (sigm_read_en)  sigm_read_data_out <= sigm_mem[sigm_read_address];
    if (hRES_write_en) hres_mem[hRES_write_address] <= hRES_write_data_in;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // scoreboard / bus monitor
  always @(negedge clk) begin
    if (X_read_en && whid_read_en) bad_bus++;
    if (X_read_en && X_read_address > 9'd447) bad_bus++;
    if (Done) done_cnt++;
    if (hRES_write_en) begin
      if (exp_q.size() == 0) unexp++;
      else begin
        check("hres_addr", 32'(hRES_write_address), 32'(exp_addr));
        check("hres_data", 32'(hRES_write_data_in), 32'(exp_q.pop_front()));
        exp_addr++;
      end
      wr_cnt++;
    end
  end

  // reference model: plain arithmetic over the RAM arrays
  task automatic build_expected();
    int acc, pre;
    exp_q.delete();
    for (int r = 0; r < 64; r++) begin
      for (int j = 0; j < 2; j++) begin
        acc = 0;
        for (int f = 0; f < 7; f++)
          acc += int'(x_mem[r*7+f]) * int'(whid_mem[j*8+1+f]);
        pre = acc / 256 + int'(whid_mem[j*8]);
        if (pre > 255) pre = 255;
        exp_q.push_back(sigm_mem[pre]);
      end
    end
  endtask

  task automatic prep();
    build_expected();
    exp_addr = '0;
    wr_cnt = 0; done_cnt = 0; bad_bus = 0; unexp = 0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_en"}, 32'({X_read_en, whid_read_en, sigm_read_en, hRES_write_en, Done}), 0);
    check({tag, "_xa"}, 32'(X_read_address), 0);
    check({tag, "_wa"}, 32'(whid_read_address), 0);
    check({tag, "_sa"}, 32'(sigm_read_address), 0);
    check({tag, "_ha"}, 32'(hRES_write_address), 0);
    check({tag, "_hd"}, 32'(hRES_write_data_in), 0);
  endtask

  // Start one run; returns the cycle (after the accept edge) on which Done
  // was seen, or the budget if it never came.
  task automatic launch(input bit noisy, input int stop_at, output int cyc);
    bit seen;
    @(negedge clk); Start = 1'b1;
    @(posedge clk);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 2000 && cyc != stop_at) begin
      @(negedge clk); cyc++;
      if (Done) seen = 1'b1;
      else Start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    Start = 1'b0;
  endtask

  task automatic run(input string tag, input bit noisy);
    int cyc;
    prep();
    launch(noisy, -1, cyc);
    check({tag, "_done_cyc"}, cyc, 722);
    repeat (20) @(negedge clk);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_writes"}, wr_cnt, 128);
    check({tag, "_unexp"}, unexp, 0);
    check({tag, "_bus"}, bad_bus, 0);
    check({tag, "_left"}, exp_q.size(), 0);
  endtask

  task automatic set_w(input int bias0, input int w0, input int bias1, input int w1);
    whid_mem[0] = 8'(bias0);
    whid_mem[8] = 8'(bias1);
    for (int i = 1; i < 8; i++) begin
      whid_mem[i]   = 8'(w0);
      whid_mem[8+i] = 8'(w1);
    end
  endtask

  task automatic sigm_identity();
    for (int k = 0; k < 256; k++) sigm_mem[k] = 8'(k);
  endtask

  task automatic set_x(input int v);
    for (int a = 0; a < 512; a++) x_mem[a] = 8'(v);
  endtask

  initial begin
    int cyc, wr_before;
    for (int a = 0; a < 128; a++) hres_mem[a] = '0;
    set_x(0); set_w(0, 0, 0, 0); sigm_identity();
    exp_addr = '0; wr_cnt = 0; done_cnt = 0; bad_bus = 0; unexp = 0;

    repeat (3) @(negedge clk);
    check_idle("reset");
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("idle");

    // all zero, sigm[k] = k ^ A5 -> every entry A5
    for (int k = 0; k < 256; k++) sigm_mem[k] = 8'(k) ^ 8'hA5;
    run("zero", 1'b0);
    check("zero_h0", 32'(hres_mem[0]), 32'hA5);
    check("zero_h127", 32'(hres_mem[127]), 32'hA5);

    // saturation: no wrap
    set_x(255); set_w(255, 255, 255, 255); sigm_identity();
    run("sat", 1'b0);
    check("sat_h5", 32'(hres_mem[5]), 255);

    // X=128: 66 / 112
    set_x(128); set_w(10, 16, 0, 32);
    run("mid", 1'b1);
    check("mid_h0", 32'(hres_mem[0]), 66);
    check("mid_h1", 32'(hres_mem[1]), 112);

    // truncation
    set_x(1); set_w(3, 1, 3, 1);
    run("trunc", 1'b0);
    check("trunc_h77", 32'(hres_mem[77]), 3);

    // per-row distinct data
    for (int r = 0; r < 64; r++)
      for (int f = 0; f < 7; f++) x_mem[r*7+f] = 8'(r + f);
    set_w(0, 8, 0, 8);
    run("rows", 1'b0);
    check("rows_h126", 32'(hres_mem[126]), (8 * (7*63 + 21)) / 256);

    // random data with random Start noise while busy
    for (int t = 0; t < 2; t++) begin
      for (int a = 0; a < 512; a++) x_mem[a] = 8'($urandom_range(0, 255));
      for (int a = 0; a < 16; a++) whid_mem[a] = 8'($urandom_range(0, 255));
      for (int k = 0; k < 256; k++) sigm_mem[k] = 8'($urandom_range(0, 255));
      run("rand", 1'b1);
    end

    // reset in the middle of a run
    prep();
    launch(1'b0, 300, cyc);
    check("rst_reach", cyc, 300);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle("midrst");
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    wr_before = wr_cnt;
    repeat (50) @(negedge clk);
    check("midrst_nowr", wr_cnt, wr_before);
    check("midrst_nodone", done_cnt, 0);
    check("midrst_bus", bad_bus, 0);
    run("post_rst", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
